bsg_router_crossbar_packet_arb: RTL
===================================

# bsg_router_crossbar_packet_arb

Packet-aware output scheduler for one output port of the router crossbar. It shares one output link among `i_els_p` ready/valid input links using round-robin arbitration. Once a header flit wins, the grant stays locked to that input until the packet's last body flit has transferred. Each crossbar output instantiates one of these, so multi-flit packets from different inputs never interleave on a link.

## Interface
Parameters:
- `i_els_p`, 2, number of competing inputs; ≥1, need not be a power of two.
- `width_p`, 10, flit width in bits.
- `len_width_p`, 3, width of the header length field `data[len_width_p-1:0]`, which gives the number of body flits following the header (0..2^len_width_p-1).

Ports:
- `clk_i`, in, 1, sole clock.
- `reset_i`, in, 1, synchronous, active-high reset.
- `valid_i`, in, `i_els_p`, per-input flit valid.
- `data_i`, in, `i_els_p` x `width_p`, per-input flit.
- `ready_and_o`, out, `i_els_p`, per-input ready; a flit transfers on input i when `valid_i[i] & ready_and_o[i]`.
- `valid_o`, out, 1, output flit valid.
- `data_o`, out, `width_p`, output flit.
- `ready_and_i`, in, 1, downstream ready; output transfer occurs when `valid_o & ready_and_i`.
- `grant_o`, out, `i_els_p`, one-hot input currently routed to the output; all-zero when none.
- `locked_o`, out, 1, high while in `eBusy`.

## Operation
- States are `eIdle` (between packets) and `eBusy` (mid-packet, grant locked).
- Registers:
  - `state_r`.
  - `rr_ptr_r`: highest-priority input index, range 0..`i_els_p-1`.
  - `lock_r`: locked input index.
  - `count_r`: remaining body flits, `len_width_p` bits.
- `eIdle`:
  - `sel` is the first i with `valid_i[i]`, scanning `rr_ptr_r`, `rr_ptr_r+1`, … with wrap from `i_els_p-1` to 0.
  - If no input is valid: `valid_o=0`, `grant_o=0`, all `ready_and_o=0`.
  - Otherwise: `valid_o=1`, `data_o=data_i[sel]`, `grant_o[sel]=1`, `ready_and_o[sel]=ready_and_i`, all others 0.
  - On a transfer with header `len = data_i[sel][len_width_p-1:0]`:
    - If `len==0`: single-flit packet; stay in `eIdle` and set `rr_ptr_r ← (sel+1) mod i_els_p`.
    - If `len>0`: go to `eBusy` with `lock_r←sel` and `count_r←len`; `rr_ptr_r` is unchanged.
- `eBusy`:
  - `valid_o=valid_i[lock_r]`, `data_o=data_i[lock_r]`, `grant_o[lock_r]=1`, `ready_and_o[lock_r]=ready_and_i`, all others 0.
  - Other inputs are ignored regardless of their valid.
  - Each transfer decrements `count_r`.
  - A transfer while `count_r==1` returns to `eIdle` with `rr_ptr_r ← (lock_r+1) mod i_els_p`.
  - If `valid_i[lock_r]` is low (bubble), the lock is held with no timeout.
- Body-flit contents are never inspected.
- Data is not stored; the block is a combinational mux plus sequencing state.
- Upstream `valid_i` must not depend on `ready_and_o`. `ready_and_o` may depend on `valid_i` of other inputs and on `ready_and_i`.

## Timing
- Zero-cycle latency: `data_o`/`valid_o` follow the granted input combinationally.
- Throughput is one flit per cycle, including back-to-back packets: the cycle after a tail transfer may carry a new header from the next round-robin input.
- Reset (synchronous, evaluated at posedge):
  - `state_r=eIdle`, `rr_ptr_r=0`, `lock_r=0`, `count_r=0`.
  - While `reset_i` is high, all outputs are forced low: `valid_o=0`, `ready_and_o=0`, `grant_o=0`, `locked_o=0`. No transfers occur.
- Reset mid-packet abandons the lock. After reset deasserts, the next flit seen is treated as a header.
- `ready_and_i=0` stalls without changing state, pointer, or grant. In `eIdle`, the selection may change while stalled if `valid_i` changes. Inputs are required to hold valid once asserted.
- With `i_els_p=1`, the pointer stays at 0 and only the packet lock is exercised.
- A maximum `len` of `2^len_width_p-1` needs no wider counter; `count_r` never underflows.

## Structure
- Package `bsg_router_crossbar_packet_arb_pkg` holds the state enum type `bsg_router_pkt_arb_state_e` { `eIdle`, `eBusy` }.
- Sub-module `bsg_router_rr_pick`: combinational rotating-priority picker. It takes `i_els_p`, `valid_i` and `ptr_i`, and returns one-hot `sel_one_hot_o`, `sel_id_o` and `v_o`. The top holds the FSM, counter, pointer and mux.

## Test plan
- **Single-flit round-robin:** `i_els_p=2`, both inputs continuously offer `len=0` headers, `ready_and_i=1` → grants alternate 0,1,0,1…, one flit per cycle, starting with input 0 after reset.
- **Lock:** input 0 sends a header with `len=3` plus 3 bodies while input 1 holds a `len=0` header → output carries 4 input-0 flits consecutively, `locked_o` is high for the 3 body cycles, and input 1 transfers on the 5th cycle.
- **Backpressure and bubble:** mid-packet, `ready_and_i=0` for 2 cycles, then `valid_i[lock]=0` for 1 cycle → no transfers and no state or pointer change; the packet completes with count intact and input 1 is never granted during the lock.
- **Wrap and non-power-of-two:** `i_els_p=3`, pointer at 2, inputs 0 and 2 valid → input 2 wins; next pointer is 0 and input 0 wins next.
- **Reset mid-packet:** assert `reset_i` after 1 of 5 body flits → all outputs are 0 during reset; afterward `rr_ptr_r=0` and the next flit from input 0 is parsed as a header.
- **Max length:** header `len=7` with `len_width_p=3` → exactly 8 flits transfer before re-arbitration.

Source files
------------

// File: rtl/bsg_router_crossbar_packet_arb_pkg.sv
// Shared types and helpers for the packet-aware crossbar output arbiter.
// Holds the arbiter state encoding and the round-robin index increment.
package bsg_router_crossbar_packet_arb_pkg;

    typedef enum logic {
        eIdle = 1'b0,
        eBusy = 1'b1
    } bsg_router_pkt_arb_state_e;

    // Next round-robin index after idx, wrapping at n (n need not be a power of two).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bsg_router_rr_pick.sv
// Rotating-priority picker: first valid input scanning from ptr_i upward with wrap.
// Latency: combinational. Backpressure: none, pure selection logic.
module bsg_router_rr_pick #(
    parameter int i_els_p    = 2,
    parameter int id_width_p = (i_els_p > 1) ? $clog2(i_els_p) : 1
) (
    input  logic [i_els_p-1:0]    valid_i,
    input  logic [id_width_p-1:0] ptr_i,
    output logic [i_els_p-1:0]    sel_one_hot_o,
    output logic [id_width_p-1:0] sel_id_o,
    output logic                  v_o
);

    logic [id_width_p:0]   w_sum;
    logic [id_width_p-1:0] w_idx;

    always_comb begin
        sel_one_hot_o = '0;
        sel_id_o      = '0;
        v_o           = 1'b0;
        w_sum         = '0;
        w_idx         = '0;
        for (int k = 0; k < i_els_p; k++) begin
            // Extra sum bit keeps ptr+k from overflowing before the wrap subtract.
            w_sum = {1'b0, ptr_i} + (id_width_p+1)'(k);
            if (w_sum >= (id_width_p+1)'(i_els_p))
                w_sum = w_sum - (id_width_p+1)'(i_els_p);
            w_idx = w_sum[id_width_p-1:0];
            if (!v_o && valid_i[w_idx]) begin
                v_o      = 1'b1;
                sel_id_o = w_idx;
            end
        end
        if (v_o)
            sel_one_hot_o[sel_id_o] = 1'b1;
    end

endmodule

// File: rtl/bsg_router_crossbar_packet_arb.sv
// Round-robin output arbiter that locks onto one input for a whole multi-flit packet.
// Latency: zero cycles, output muxed combinationally. Backpressure: ready_and_i fans to granted input only.
module bsg_router_crossbar_packet_arb
    import bsg_router_crossbar_packet_arb_pkg::*;
#(
    parameter int i_els_p     = 2,
    parameter int width_p     = 10,
    parameter int len_width_p = 3
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [i_els_p-1:0]                valid_i,
    input  logic [i_els_p-1:0][width_p-1:0]   data_i,
    output logic [i_els_p-1:0]                ready_and_o,
    output logic                              valid_o,
    output logic [width_p-1:0]                data_o,
    input  logic                              ready_and_i,
    output logic [i_els_p-1:0]                grant_o,
    output logic                              locked_o
);

    localparam int id_width_lp = (i_els_p > 1) ? $clog2(i_els_p) : 1;

    bsg_router_pkt_arb_state_e state_r, state_n;
    logic [id_width_lp-1:0]    rr_ptr_r, rr_ptr_n;
    logic [id_width_lp-1:0]    lock_r, lock_n;
    logic [len_width_p-1:0]    count_r, count_n;

    logic [i_els_p-1:0]        w_pick_one_hot;
    logic [id_width_lp-1:0]    w_pick_id;
    logic                      w_pick_v;
    logic                      w_busy;
    logic [id_width_lp-1:0]    w_sel_id;
    logic [i_els_p-1:0]        w_grant;
    logic                      w_any;
    logic                      w_xfer;
    logic [len_width_p-1:0]    w_len;

    bsg_router_rr_pick #(
        .i_els_p    (i_els_p),
        .id_width_p (id_width_lp)
    ) u_pick (
        .valid_i       (valid_i),
        .ptr_i         (rr_ptr_r),
        .sel_one_hot_o (w_pick_one_hot),
        .sel_id_o      (w_pick_id),
        .v_o           (w_pick_v)
    );

    always_comb begin
        w_busy   = (state_r == eBusy);
        w_sel_id = w_busy ? lock_r : w_pick_id;
        w_grant  = '0;
        if (w_busy)
            w_grant[lock_r] = 1'b1;
        else
            w_grant = w_pick_one_hot;
        w_any = w_busy ? valid_i[lock_r] : w_pick_v;
        if (reset_i) begin
            w_grant = '0;
            w_any   = 1'b0;
        end
        w_xfer      = w_any & ready_and_i;
        w_len       = data_i[w_sel_id][len_width_p-1:0];

        valid_o     = w_any;
        data_o      = data_i[w_sel_id];
        grant_o     = w_grant;
        ready_and_o = w_grant & {i_els_p{ready_and_i}};
        locked_o    = w_busy & ~reset_i;

        state_n  = state_r;
        rr_ptr_n = rr_ptr_r;
        lock_n   = lock_r;
        count_n  = count_r;
        case (state_r)
            eIdle: begin
                if (w_xfer) begin
                    if (w_len == '0) begin
                        rr_ptr_n = id_width_lp'(wrap_inc(int'(w_pick_id), i_els_p));
                    end else begin
                        state_n = eBusy;
                        lock_n  = w_pick_id;
                        count_n = w_len;
                    end
                end
            end
            eBusy: begin
                if (w_xfer) begin
                    count_n = count_r - len_width_p'(1);
                    if (count_r == len_width_p'(1)) begin
                        state_n  = eIdle;
                        rr_ptr_n = id_width_lp'(wrap_inc(int'(lock_r), i_els_p));
                    end
                end
            end
            default: state_n = eIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= eIdle;
            rr_ptr_r <= '0;
            lock_r   <= '0;
            count_r  <= '0;
        end else begin
            state_r  <= state_n;
            rr_ptr_r <= rr_ptr_n;
            lock_r   <= lock_n;
            count_r  <= count_n;
        end
    end

endmodule
